xor_accum: RTL

Parametrised streaming XOR reducer that generalises the two-input XOR gate to a WIDTH-bit, multi-word datapath. It folds a frame of up to FRAME_LEN input words into one XOR result word plus a parity bit, with valid/ready handshakes on both sides. It is used as a checksum or parity stage between a word source and a downstream consumer that can stall.

---
 rtl/xor_accum.sv | 100 ++++++++++
 1 files changed

// File: rtl/xor_accum.sv
// Streaming XOR reducer: folds up to FRAME_LEN words into one result word,
// a word count and a parity bit, with valid/ready handshakes on both sides.
module xor_accum #(
    parameter int WIDTH      = 8,
    parameter int FRAME_LEN  = 4,
    parameter int ODD_PARITY = 0,
    localparam int CW        = $clog2(FRAME_LEN + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_word,
    output logic             out_parity,
    output logic [CW-1:0]    out_count
);

    localparam logic [0:0] ST_ACCUM = 1'b0;
    localparam logic [0:0] ST_HOLD  = 1'b1;

    function automatic logic parity_of(input logic [WIDTH-1:0] v);
        parity_of = ^v;
    endfunction

    logic [0:0]       r_state;
    logic [WIDTH-1:0] r_acc;
    logic [CW-1:0]    r_cnt;
    logic [WIDTH-1:0] r_out_word;
    logic [CW-1:0]    r_out_count;

    logic             w_accept;
    logic             w_close;
    logic [CW-1:0]    w_cnt_inc;
    logic [WIDTH-1:0] w_acc_next;

    // Accept/close decision for the word presented this cycle
    always_comb begin
        w_accept   = 1'b0;
        w_close    = 1'b0;
        w_cnt_inc  = r_cnt + CW'(1);
        w_acc_next = r_acc ^ in_data;
        if (r_state == ST_ACCUM) begin
            w_accept = in_valid;
        end else begin
            w_accept = 1'b0;
        end
        // FRAME_LEN-th word and in_last together still close only one frame
        if (w_accept && (in_last || (w_cnt_inc == CW'(FRAME_LEN)))) begin
            w_close = 1'b1;
        end else begin
            w_close = 1'b0;
        end
    end

    // Accumulator, counter, result registers and two-state control
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_ACCUM;
            r_acc       <= {WIDTH{1'b0}};
            r_cnt       <= {CW{1'b0}};
            r_out_word  <= {WIDTH{1'b0}};
            r_out_count <= {CW{1'b0}};
        end else begin
            case (r_state)
                ST_ACCUM: begin
                    if (w_accept) begin
                        r_acc <= w_acc_next;
                        r_cnt <= w_cnt_inc;
                        if (w_close) begin
                            r_out_word  <= w_acc_next;
                            r_out_count <= w_cnt_inc;
                            r_state     <= ST_HOLD;
                        end
                    end
                end
                ST_HOLD: begin
                    if (out_ready) begin
                        r_acc   <= {WIDTH{1'b0}};
                        r_cnt   <= {CW{1'b0}};
                        r_state <= ST_ACCUM;
                    end
                end
                default: begin
                    r_state <= ST_ACCUM;
                end
            endcase
        end
    end

    assign in_ready   = (r_state == ST_ACCUM);
    assign out_valid  = (r_state == ST_HOLD);
    assign out_word   = r_out_word;
    assign out_count  = r_out_count;
    assign out_parity = parity_of(r_out_word) ^ 1'(ODD_PARITY);

endmodule
